// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: state encoding
// and default configuration values.
package pc_pkg;

  localparam int unsigned PC_XLEN_DEFAULT = 32;
  localparam logic [PC_XLEN_DEFAULT-1:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // Encoding is visible on the state output port: 0=BOOT, 1=RUN, 2=HALT.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. Overflow overwrites the oldest entry,
// pop when empty is ignored, push+pop together replace the top entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned XLEN  = PC_XLEN_DEFAULT,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            valid
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;   // next free slot
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   top_idx;
  logic [PW-1:0]   ptr_inc;

  assign top_idx = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;
  assign ptr_inc = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign valid   = (cnt_q != '0);
  assign top     = valid ? mem_q[top_idx] : '0;

  // Next stack contents, write pointer and occupancy
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push && pop && (cnt_q != '0)) begin
      mem_d[top_idx] = push_data;
    end else if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_inc;
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + 1'b1;
    end else if (pop && (cnt_q != '0)) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Stack state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT control, prioritised redirects
// (trap > jmp > branch > halt > stall > increment), misalignment trapping.
// Optional return-address stack enabled by defining RAS_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = PC_XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = PC_RESET_VECTOR_DEFAULT,
  parameter int unsigned     STEP         = 4,
  parameter int unsigned     ALIGN_BITS   = 2,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            call,
  input  logic            ret,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_plus,
  output logic            PC_valid,
  output logic            misalign,
  output logic [1:0]      state,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic            ras_push, ras_pop;
  logic [XLEN-1:0] trap_masked;

  assign trap_masked = trap_vec & ~LOW_MASK;
  assign PC          = pc_q;
  assign PC_plus     = pc_q + XLEN'(STEP);
  assign PC_valid    = (state_q == RUN);
  assign misalign    = misalign_q;
  assign state       = state_q;

  // Next-state / next-PC selection
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        ras_pop = ret;
        if (trap) begin
          pc_d = trap_masked;
        end else if (jmp) begin
          if ((jmp_target & LOW_MASK) != '0) begin
            pc_d       = trap_masked;
            misalign_d = 1'b1;
          end else begin
            pc_d     = jmp_target;
            ras_push = call;
          end
        end else if (br_taken) begin
          if ((br_target & LOW_MASK) != '0) begin
            pc_d       = trap_masked;
            misalign_d = 1'b1;
          end else begin
            pc_d = br_target;
          end
        end else if (halt_req) begin
          state_d = HALT;
        end else if (!stall) begin
          pc_d = PC_plus;
        end
      end
      HALT: begin
        if (trap) begin
          pc_d    = trap_masked;
          state_d = RUN;
        end else if (resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // PC, state and misalign registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef RAS_EN
  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (PC_plus),
    .top       (ras_top),
    .valid     (ras_valid)
  );
`else
  logic unused_ras;
  assign unused_ras = ^{call, ret, ras_push, ras_pop};
  assign ras_top    = '0;
  assign ras_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen. Define RAS_EN to also check
// the return-address stack contents.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, stall, halt_req, resume, br_taken, jmp, call, ret, trap;
  logic [31:0] br_target, jmp_target, trap_vec;
  logic [31:0] PC, PC_plus, ras_top;
  logic        PC_valid, misalign, ras_valid;
  logic [1:0]  state;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .STEP         (4),
    .ALIGN_BITS   (2),
    .RAS_DEPTH    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .halt_req   (halt_req),
    .resume     (resume),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .call       (call),
    .ret        (ret),
    .trap       (trap),
    .trap_vec   (trap_vec),
    .PC         (PC),
    .PC_plus    (PC_plus),
    .PC_valid   (PC_valid),
    .misalign   (misalign),
    .state      (state),
    .ras_top    (ras_top),
    .ras_valid  (ras_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; halt_req = 0; resume = 0; br_taken = 0; jmp = 0;
    call = 0; ret = 0; trap = 0;
    br_target = '0; jmp_target = '0; trap_vec = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    tick(); tick();
    // 1. reset and boot
    check("rst_pc", PC, 32'h0);
    check("rst_valid", {31'b0, PC_valid}, 32'h0);
    check("rst_state", {30'b0, state}, 32'h0);
    check("rst_misalign", {31'b0, misalign}, 32'h0);
    check("rst_ras_valid", {31'b0, ras_valid}, 32'h0);
    check("rst_ras_top", ras_top, 32'h0);
    rst = 1'b1;
    #1;
    check("boot_valid", {31'b0, PC_valid}, 32'h0);
    check("boot_state", {30'b0, state}, 32'h0);
    tick();
    check("run0_pc", PC, 32'h0);
    check("run0_valid", {31'b0, PC_valid}, 32'h1);
    check("run0_state", {30'b0, state}, 32'h1);
    tick();
    check("run1_pc", PC, 32'h4);
    tick();
    check("run2_pc", PC, 32'h8);
    check("run2_pc_plus", PC_plus, 32'hC);
    tick(); tick();
    check("run4_pc", PC, 32'h10);

    // 2. redirect priority
    trap = 1; trap_vec = 32'h203; jmp = 1; jmp_target = 32'h100;
    br_taken = 1; br_target = 32'h40;
    tick();
    check("prio_trap_pc", PC, 32'h200);
    check("prio_trap_misalign", {31'b0, misalign}, 32'h0);
    clear_inputs();
    br_taken = 1; br_target = 32'h40;
    tick();
    check("br_pc", PC, 32'h40);
    clear_inputs();

    // 3. stall vs redirect
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", PC, 32'h40);
    end
    br_taken = 1; br_target = 32'h80;
    tick();
    check("stall_br_pc", PC, 32'h80);
    clear_inputs();
    tick();
    check("after_br_pc", PC, 32'h84);

    // 4. misaligned targets
    jmp = 1; jmp_target = 32'h102; trap_vec = 32'h300;
    tick();
    check("mis_jmp_pc", PC, 32'h300);
    check("mis_jmp_flag", {31'b0, misalign}, 32'h1);
    clear_inputs();
    tick();
    check("mis_clear_flag", {31'b0, misalign}, 32'h0);
    check("mis_clear_pc", PC, 32'h304);
    br_taken = 1; br_target = 32'h41; trap_vec = 32'h300;
    tick();
    check("mis_br_pc", PC, 32'h300);
    check("mis_br_flag", {31'b0, misalign}, 32'h1);
    clear_inputs();
    tick();
    check("mis_br_clear", {31'b0, misalign}, 32'h0);

    // 5. halt / resume / wrap
    halt_req = 1;
    tick();
    check("halt_state", {30'b0, state}, 32'h2);
    check("halt_valid", {31'b0, PC_valid}, 32'h0);
    check("halt_pc", PC, 32'h304);
    halt_req = 0;
    tick();
    check("halt_hold_pc", PC, 32'h304);
    check("halt_hold_state", {30'b0, state}, 32'h2);
    halt_req = 1; resume = 1;
    tick();
    check("resume_state", {30'b0, state}, 32'h1);
    check("resume_pc", PC, 32'h304);
    check("resume_valid", {31'b0, PC_valid}, 32'h1);
    clear_inputs();
    tick();
    check("resume_count", PC, 32'h308);
    halt_req = 1;
    tick();
    clear_inputs();
    trap = 1; trap_vec = 32'h503;
    tick();
    check("halt_trap_state", {30'b0, state}, 32'h1);
    check("halt_trap_pc", PC, 32'h500);
    clear_inputs();
    jmp = 1; jmp_target = 32'hFFFF_FFFC;
    tick();
    check("wrap_pre_pc", PC, 32'hFFFF_FFFC);
    check("wrap_pc_plus", PC_plus, 32'h0);
    clear_inputs();
    tick();
    check("wrap_pc", PC, 32'h0);
    check("wrap_misalign", {31'b0, misalign}, 32'h0);

    // 6. return-address stack (depth 2, three calls)
    jmp = 1; jmp_target = 32'h10;
    tick();
    call = 1; jmp_target = 32'h20;
    tick();
    jmp_target = 32'h30;
    tick();
    jmp_target = 32'h100;
    tick();
    check("call_pc", PC, 32'h100);
    clear_inputs();
`ifdef RAS_EN
    check("ras_top0", ras_top, 32'h34);
    check("ras_valid0", {31'b0, ras_valid}, 32'h1);
    ret = 1;
    tick();
    check("ras_top1", ras_top, 32'h24);
    check("ras_valid1", {31'b0, ras_valid}, 32'h1);
    tick();
    check("ras_valid2", {31'b0, ras_valid}, 32'h0);
    check("ras_top2", ras_top, 32'h0);
    tick();
    check("ras_empty_pop", {31'b0, ras_valid}, 32'h0);
    clear_inputs();
    jmp = 1; call = 1; jmp_target = 32'h102; trap_vec = 32'h300;
    tick();
    check("ras_mis_nopush", {31'b0, ras_valid}, 32'h0);
    check("ras_mis_pc", PC, 32'h300);
    clear_inputs();
`else
    check("noras_valid", {31'b0, ras_valid}, 32'h0);
    check("noras_top", ras_top, 32'h0);
    ret = 1;
    tick();
    check("noras_ret_valid", {31'b0, ras_valid}, 32'h0);
    clear_inputs();
`endif

    // reset mid-operation overrides pending redirect
    br_taken = 1; br_target = 32'h80; rst = 0;
    tick();
    check("midrst_pc", PC, 32'h0);
    check("midrst_state", {30'b0, state}, 32'h0);
    check("midrst_valid", {31'b0, PC_valid}, 32'h0);
    check("midrst_ras", {31'b0, ras_valid}, 32'h0);
    clear_inputs();
    rst = 1;
    tick();
    check("midrst_boot_pc", PC, 32'h0);
    check("midrst_run_state", {30'b0, state}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator. Successor to the single-register Program_Counter.
- Sits at the front of the fetch path.
- Selects the next PC from sequential increment, branch, jump and trap redirects.
- Adds stall/halt control, a boot state, misalignment trapping and an optional return-address stack.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- STEP, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of low PC bits that must be zero (1 when compressed instructions are supported).
- RAS_DEPTH, 4, return-stack entries (used only with RAS_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- stall  in  1  hold the current PC.
- halt_req  in  1  enter HALT.
- resume  in  1  leave HALT.
- br_taken  in  1  branch redirect.
- br_target  in  XLEN  branch target.
- jmp  in  1  jump redirect.
- jmp_target  in  XLEN  jump target.
- call  in  1  qualifies jmp as a call (RAS push).
- ret  in  1  pop the return stack.
- trap  in  1  trap redirect.
- trap_vec  in  XLEN  trap handler address.
- PC  out  XLEN  current PC.
- PC_plus  out  XLEN  PC+STEP (combinational).
- PC_valid  out  1  PC is fetchable this cycle.
- misalign  out  1  one-cycle pulse: misaligned target trapped.
- state  out  2  0=BOOT, 1=RUN, 2=HALT.
- ras_top  out  XLEN  predicted return address.
- ras_valid  out  1  ras_top is meaningful.

Behaviour:
- All state updates on the rising edge of clk. rst is synchronous and active-low.
- Reset (rst==0 at an edge):
  - PC=RESET_VECTOR, state=BOOT.
  - PC_valid=0, misalign=0.
  - RAS empty: ras_valid=0, ras_top=0.
- BOOT:
  - Lasts exactly one cycle after reset release.
  - PC is held; next state is RUN.
  - All other inputs are ignored.
- RUN next-PC priority, highest first:
  - trap → trap_vec with the low ALIGN_BITS bits forced to 0.
  - jmp → jmp_target.
  - br_taken → br_target.
  - halt_req → PC held, state becomes HALT.
  - stall → PC held.
  - otherwise → PC+STEP.
- Redirect latency: the redirect target appears on PC in the cycle after the request, i.e. one cycle.
- Redirect vs stall: a redirect overrides stall in the same cycle.
- Misaligned target: if a selected jmp/br target has any of the low ALIGN_BITS bits set:
  - PC <= masked trap_vec instead of the target.
  - misalign=1 for exactly that following cycle.
  - No RAS push occurs.
- Wrap-around: PC+STEP is computed modulo 2^XLEN, so PC=0xFFFF_FFFC → 0x0000_0000 with no flag.
- PC_valid is 1 in RUN and 0 in BOOT and HALT.
- HALT:
  - PC held.
  - resume → RUN with PC unchanged.
  - trap → RUN with PC = masked trap_vec.
  - halt_req and resume in the same cycle → resume wins.
- Reset mid-operation: reset overrides everything, including pending redirects and halt.

Optional Feature:
- Macro RAS_EN.
- Defined:
  - RAS_DEPTH-entry circular return stack.
  - Push PC_plus when jmp && call in RUN with an aligned target.
  - Pop when ret.
  - Push and pop in the same cycle replace the top entry.
  - Overflow overwrites the oldest entry.
  - Pop when empty is ignored.
  - ras_valid = (count != 0).
- Undefined: ports remain; ras_top=0, ras_valid=0; call and ret are ignored.

Decomposition:
- Shared package pc_pkg:
  - state encoding constants BOOT/RUN/HALT.
  - default XLEN.
  - RESET_VECTOR default.
- One natural sub-module: pc_ras (circular return stack, depth parameter), instantiated only under RAS_EN.

Test Plan:
1. Reset/boot: rst=0 for 2 cycles, then 1 → PC=0x0 with PC_valid=0 for one cycle, then PC=0x0, 0x4, 0x8 with valid=1.
2. Redirect priority: at PC=0x10, assert trap (trap_vec=0x203), jmp=0x100 and br=0x40 together → next PC=0x200. Then br_taken alone with target 0x40 → PC=0x40.
3. Stall vs redirect: stall held 3 cycles → PC constant. Stall plus br_taken(0x80) → PC=0x80 next cycle.
4. Misalign: jmp_target=0x102 with trap_vec=0x300 → PC=0x300, misalign=1 for exactly one cycle.
5. Halt/resume and wrap:
   - halt_req → PC_valid=0, state=2, PC frozen.
   - resume → counting restarts from the frozen PC.
   - Force PC=0xFFFF_FFFC via jmp → PC wraps to 0x0.
6. RAS_EN:
   - With RAS_DEPTH=2, call three times from 0x10, 0x20 and 0x30.
   - Pop → ras_top=0x34, then 0x24, then ras_valid=0.
